clk_rst_seq: RTL and testbench

Parametrised clock-enable and reset sequencer for the single-cycle MIPS data path.
- Inputs: board clock and the lock indications from up to NLOCK clock generators.
- Outputs: NCH active-high CPU-side resets, released one by one in a fixed order, plus a ready flag and an optional divided clock enable.
- Differences from a plain lock-AND reset: filters lock glitches, staggers reset release (core, INST_MEM, DATA_MEM, peripherals), re-sequences after lock loss or software request, and counts lock-loss events.

---
 rtl/clk_rst_pkg.sv | 26 ++
 rtl/clk_rst_seq_if.sv | 19 +
 rtl/rst_sync_bit.sv | 24 ++
 rtl/clk_rst_seq.sv | 169 ++++++++++++++++
 tb/tb_clk_rst_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock-enable / reset sequencer.
// FSM encoding, loss counter width and default parameter values.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

    localparam int DEF_NLOCK       = 2;
    localparam int DEF_NCH         = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_CYCLES = 16;
    localparam int DEF_STAGGER     = 4;
    localparam int DEF_CE_DIV      = 2;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// Lock/soft-reset inputs and reset/status outputs of the sequencer.
// The master side drives locks and requests; the slave side is the sequencer.
interface clk_rst_seq_if #(
    parameter int NLOCK = 2,
    parameter int NCH   = 3
);
    import clk_rst_pkg::*;

    logic [NLOCK-1:0]      lock_in;
    logic                  soft_rst;
    logic [NCH-1:0]        crst;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] loss_cnt;
    logic                  ce;

    modport master (output lock_in, soft_rst, input crst, ready, loss_cnt, ce);
    modport slave  (input lock_in, soft_rst, output crst, ready, loss_cnt, ce);

endinterface

// File: rtl/rst_sync_bit.sv
// Single-bit synchroniser chain, SYNC_STAGES flops deep.
// Cleared asynchronously so a reset sequencer never sees stale lock state.
module rst_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Lock-filtered, staggered reset sequencer with lock-loss counter.
// Optional divided clock enable when CLK_RST_SEQ_CE_EN is defined.
//
// state     | meaning
// WAIT_LOCK | all channels in reset, waiting for lock and no soft request
// STABLE    | counting consecutive locked cycles
// RELEASE   | releasing channels one by one, STAGGER cycles apart
// RUN       | all channels released, ready high
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NLOCK       = DEF_NLOCK,
    parameter int NCH         = DEF_NCH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int CE_DIV      = DEF_CE_DIV
) (
    input  logic          CLK,
    input  logic          RST,
    clk_rst_seq_if.slave  bus
);

    localparam int CNT_W  = cnt_w(LOCK_CYCLES);
    localparam int STAG_W = cnt_w(STAGGER);
    localparam int K_W    = cnt_w(NCH);

    if (SYNC_STAGES < 2 || LOCK_CYCLES < 1 || STAGGER < 1 || CE_DIV < 2) begin : g_bad_param
        $error("clk_rst_seq: parameter out of range");
    end

    logic [NLOCK-1:0] lock_all;
    logic             lk_s;
    logic             sr_s;

    assign lock_all = bus.lock_in;

    rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lk_sync (
        .clk(CLK), .rst_n(RST), .d(&lock_all), .q(lk_s)
    );

    rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sr_sync (
        .clk(CLK), .rst_n(RST), .d(bus.soft_rst), .q(sr_s)
    );

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STAG_W-1:0]     stag_q, stag_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [NCH-1:0]        crst_q, crst_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stag_q  <= '0;
            k_q     <= '0;
            crst_q  <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stag_q  <= stag_d;
            k_q     <= k_d;
            crst_q  <= crst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stag_d  = stag_q;
        k_d     = k_q;
        crst_d  = crst_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        // A single abort edge counts at most once, whatever caused it.
        if (state_q != WAIT_LOCK && (!lk_s || sr_s)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            stag_d  = '0;
            k_d     = '0;
            crst_d  = '1;
            ready_d = 1'b0;
            if (!lk_s && (state_q == RELEASE || state_q == RUN) && loss_q != '1) begin
                loss_d = loss_q + 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    crst_d  = '1;
                    ready_d = 1'b0;
                    if (lk_s && !sr_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d   = RELEASE;
                        crst_d[0] = 1'b0;
                        k_d       = '0;
                        stag_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (k_q == K_W'(NCH - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else if (stag_q == STAG_W'(STAGGER - 1)) begin
                        stag_d = '0;
                        k_d    = k_q + 1'b1;
                        for (int i = 0; i < NCH; i++) begin
                            if (i == int'(k_q) + 1) crst_d[i] = 1'b0;
                        end
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    crst_d  = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.crst     = crst_q;
    assign bus.ready    = ready_q;
    assign bus.loss_cnt = loss_q;

`ifdef CLK_RST_SEQ_CE_EN
    localparam int DIV_W = cnt_w(CE_DIV);

    logic [DIV_W-1:0] div_q;
    logic             ce_q;

    // Divider only runs while staying in RUN, so the first pulse lands in the CE_DIV-th RUN cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else if (state_q == RUN && state_d == RUN) begin
            div_q <= (div_q == DIV_W'(CE_DIV - 1)) ? '0 : div_q + 1'b1;
            ce_q  <= (div_q == DIV_W'(CE_DIV - 2));
        end else begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end
    end

    assign bus.ce = ce_q;
`else
    assign bus.ce = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with NLOCK=2, NCH=3, LOCK_CYCLES=16, STAGGER=4.
// Edge n counts posedges after the stimulus change; outputs sampled #1 after each edge.
module tb_clk_rst_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    clk_rst_seq_if #(.NLOCK(2), .NCH(3)) bus ();

    clk_rst_seq #(
        .NLOCK(2), .NCH(3), .SYNC_STAGES(2),
        .LOCK_CYCLES(16), .STAGGER(4), .CE_DIV(2)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs edges until ready rises (bounded), recording first edge each channel is released.
    task automatic run_seq(input int drop_at, input int restore_at,
                           output int e0, output int e1, output int e2, output int er,
                           output int ce_early);
        e0 = -1; e1 = -1; e2 = -1; er = -1; ce_early = 0;
        for (int n = 1; n <= 80 && er < 0; n++) begin
            step();
            if (e0 < 0 && bus.crst[0] === 1'b0) e0 = n;
            if (e1 < 0 && bus.crst[1] === 1'b0) e1 = n;
            if (e2 < 0 && bus.crst[2] === 1'b0) e2 = n;
            if (er < 0 && bus.ready === 1'b1) er = n;
            if (bus.ready !== 1'b1 && bus.ce !== 1'b0) ce_early++;
            if (n == drop_at) bus.lock_in = 2'b01;
            if (n == restore_at) bus.lock_in = 2'b11;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.lock_in = 2'b00;
        bus.soft_rst = 1'b0;
        repeat (5) step();
        n_checks++; if (bus.crst !== 3'b111) begin n_fail++; $display("FAIL reset_crst: got %b expected 111", bus.crst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d expected 0", bus.loss_cnt); end
        n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", bus.ce); end
    endtask

    task automatic test_power_up();
        int e0, e1, e2, er, cee;
        logic ce_exp;
        rst_n = 1'b1;
        bus.lock_in = 2'b11;
        run_seq(-1, -1, e0, e1, e2, er, cee);
        n_checks++; if (e0 !== 19) begin n_fail++; $display("FAIL pu_crst0: got edge %0d expected 19", e0); end
        n_checks++; if (e1 !== 23) begin n_fail++; $display("FAIL pu_crst1: got edge %0d expected 23", e1); end
        n_checks++; if (e2 !== 27) begin n_fail++; $display("FAIL pu_crst2: got edge %0d expected 27", e2); end
        n_checks++; if (er !== 28) begin n_fail++; $display("FAIL pu_ready: got edge %0d expected 28", er); end
        n_checks++; if (cee !== 0) begin n_fail++; $display("FAIL pu_ce_before_ready: got %0d pulses expected 0", cee); end
        n_checks++; if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL pu_loss: got %0d expected 0", bus.loss_cnt); end
        // Edge 28 is the first RUN edge; with CE_DIV=2 ce reads 0,1,0,1 from there.
        for (int k = 0; k < 4; k++) begin
`ifdef CLK_RST_SEQ_CE_EN
            ce_exp = (k % 2 == 1);
`else
            ce_exp = 1'b0;
`endif
            n_checks++; if (bus.ce !== ce_exp) begin n_fail++; $display("FAIL ce_run[%0d]: got %b expected %b", k, bus.ce, ce_exp); end
            step();
        end
    endtask

    task automatic test_lock_loss();
        int e0, e1, e2, er, cee;
        bus.lock_in = 2'b10;
        step(); step();
        n_checks++; if (bus.crst !== 3'b000 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL loss_early: got crst=%b ready=%b expected 000/1", bus.crst, bus.ready); end
        step();
        n_checks++; if (bus.crst !== 3'b111) begin n_fail++; $display("FAIL loss_crst: got %b expected 111", bus.crst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d expected 1", bus.loss_cnt); end
        n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL loss_ce: got %b expected 0", bus.ce); end
        bus.lock_in = 2'b11;
        run_seq(-1, -1, e0, e1, e2, er, cee);
        n_checks++; if (e0 !== 19 || e1 !== 23 || e2 !== 27 || er !== 28) begin n_fail++; $display("FAIL relock_seq: got %0d/%0d/%0d/%0d expected 19/23/27/28", e0, e1, e2, er); end
    endtask

    task automatic test_soft_reset();
        int e0, e1, e2, er, cee;
        bus.soft_rst = 1'b1;
        step(); step(); step();
        n_checks++; if (bus.crst !== 3'b111 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL soft_abort: got crst=%b ready=%b expected 111/0", bus.crst, bus.ready); end
        step();
        bus.soft_rst = 1'b0;
        // Edges continue from 5; STABLE entered at edge 7, so release at 23/27/31, ready at 32.
        run_seq(-1, -1, e0, e1, e2, er, cee);
        n_checks++; if (e0 + 4 !== 23 || e1 + 4 !== 27 || e2 + 4 !== 31 || er + 4 !== 32) begin n_fail++; $display("FAIL soft_seq: got %0d/%0d/%0d/%0d expected 23/27/31/32", e0 + 4, e1 + 4, e2 + 4, er + 4); end
        n_checks++; if (bus.loss_cnt !== 8'd1) begin n_fail++; $display("FAIL soft_loss: got %0d expected 1", bus.loss_cnt); end
    endtask

    task automatic test_rst_mid_release();
        bus.lock_in = 2'b00;
        repeat (3) step();
        n_checks++; if (bus.loss_cnt !== 8'd2) begin n_fail++; $display("FAIL mid_loss_before: got %0d expected 2", bus.loss_cnt); end
        bus.lock_in = 2'b11;
        repeat (21) step();
        n_checks++; if (bus.crst !== 3'b110) begin n_fail++; $display("FAIL mid_release_crst: got %b expected 110", bus.crst); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.crst !== 3'b111 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL async_rst: got crst=%b ready=%b expected 111/0", bus.crst, bus.ready); end
        n_checks++; if (bus.loss_cnt !== 8'd0 || bus.ce !== 1'b0) begin n_fail++; $display("FAIL async_rst_cnt: got loss=%0d ce=%b expected 0/0", bus.loss_cnt, bus.ce); end
        step(); step();
    endtask

    task automatic test_glitch();
        int e0, e1, e2, er, cee;
        rst_n = 1'b1;
        bus.lock_in = 2'b11;
        // lock_in[1] low for edges 11..13: lk_s low 13..15, STABLE restarts at 16, release at 32.
        run_seq(10, 13, e0, e1, e2, er, cee);
        n_checks++; if (e0 !== 32) begin n_fail++; $display("FAIL glitch_crst0: got edge %0d expected 32", e0); end
        n_checks++; if (e1 !== 36 || e2 !== 40 || er !== 41) begin n_fail++; $display("FAIL glitch_seq: got %0d/%0d/%0d expected 36/40/41", e1, e2, er); end
        n_checks++; if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_loss: got %0d expected 0", bus.loss_cnt); end
    endtask

    task automatic test_saturation();
        int to;
        for (int ev = 0; ev < 300; ev++) begin
            if (ev == 254) begin
                n_checks++; if (bus.loss_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_pre: got %0d expected 254", bus.loss_cnt); end
            end
            bus.lock_in = 2'b11;
            to = 0;
            while (bus.crst[0] !== 1'b0 && to < 60) begin step(); to++; end
            if (to >= 60) begin n_checks++; n_fail++; $display("FAIL sat_release_timeout: event %0d crst=%b expected crst[0]=0", ev, bus.crst); break; end
            bus.lock_in = 2'b00;
            to = 0;
            while (bus.crst !== 3'b111 && to < 10) begin step(); to++; end
            if (to >= 10) begin n_checks++; n_fail++; $display("FAIL sat_abort_timeout: event %0d crst=%b expected 111", ev, bus.crst); break; end
        end
        n_checks++; if (bus.loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255", bus.loss_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.lock_in = 2'b00;
        bus.soft_rst = 1'b0;
        test_reset();
        test_power_up();
        test_lock_loss();
        test_soft_reset();
        test_rst_mid_release();
        test_glitch();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
